// File: rtl/fetch_ras_unit.sv
// Fetch program counter with a hardware return-address stack.
// Ops: NOP, INC, CALL, RET, JUMP; sticky overflow/underflow flags.
module fetch_ras_unit #(
  parameter int PC_WIDTH = 16,
  parameter int RAS_DEPTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter bit OVERFLOW_WRAP = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   op_i,
  input  logic [1:0]                   step_i,
  input  logic [PC_WIDTH-1:0]          target_i,
  input  logic                         clear_flags_i,
  output logic [PC_WIDTH-1:0]          pc_o,
  output logic [PC_WIDTH-1:0]          top_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ras_overflow_o,
  output logic                         ras_underflow_o
);

  localparam int HW = $clog2(RAS_DEPTH);
  localparam int CW = HW + 1;

  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_JUMP = 3'd4;

  logic [PC_WIDTH-1:0] ras [RAS_DEPTH];
  logic [PC_WIDTH-1:0] pc, pc_n, ra;
  logic [HW-1:0]       head, head_n, top_idx;
  logic [CW-1:0]       count, count_n;
  logic                ovf, unf;
  logic                ovf_set, unf_set;
  logic                we;
  logic                full, empty;

  assign ra      = pc + PC_WIDTH'(step_i);
  assign top_idx = head - HW'(1);
  assign full    = (count == CW'(RAS_DEPTH));
  assign empty   = (count == '0);

  // Decode the op into next PC, stack pointer moves and flag events
  always_comb begin
    pc_n    = pc;
    head_n  = head;
    count_n = count;
    we      = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op_i)
      OP_INC:  pc_n = ra;
      OP_JUMP: pc_n = target_i;
      OP_CALL: begin
        pc_n = target_i;
        if (!full) begin
          we      = 1'b1;
          head_n  = head + HW'(1);
          count_n = count + CW'(1);
        end else begin
          ovf_set = 1'b1;
          if (OVERFLOW_WRAP) begin
            we     = 1'b1;
            head_n = head + HW'(1);
          end
        end
      end
      OP_RET: begin
        if (!empty) begin
          pc_n    = ras[top_idx];
          head_n  = top_idx;
          count_n = count - CW'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // PC, pointers and sticky flags; a set event beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      head  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      pc    <= pc_n;
      head  <= head_n;
      count <= count_n;
      ovf   <= ovf_set | (ovf & ~clear_flags_i);
      unf   <= unf_set | (unf & ~clear_flags_i);
    end
  end

  // Stack storage: one write per cycle, never cleared
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      ras[head] <= ra;
    end
  end

  assign pc_o            = pc;
  assign top_o           = empty ? '0 : ras[top_idx];
  assign ras_count_o     = count;
  assign ras_overflow_o  = ovf;
  assign ras_underflow_o = unf;

endmodule

// File: tb/tb_fetch_ras_unit.sv
// Scoreboard bench for fetch_ras_unit, wrap and drop variants.
// Reference keeps the stack as an oldest-first array.
module tb_fetch_ras_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  op;
  logic [1:0]  step;
  logic [15:0] tgt;
  logic        clr;

  logic [15:0] pc0, top0, pc1, top1;
  logic [3:0]  cnt0, cnt1;
  logic        ov0, un0, ov1, un1;

  always #5 clk = ~clk;

  fetch_ras_unit #(
    .PC_WIDTH(16), .RAS_DEPTH(8),
    .RESET_PC(16'h0000), .OVERFLOW_WRAP(1'b1)
  ) dut0 (
    .clk(clk), .rst(rst), .op_i(op), .step_i(step),
    .target_i(tgt), .clear_flags_i(clr),
    .pc_o(pc0), .top_o(top0), .ras_count_o(cnt0),
    .ras_overflow_o(ov0), .ras_underflow_o(un0)
  );

  fetch_ras_unit #(
    .PC_WIDTH(16), .RAS_DEPTH(8),
    .RESET_PC(16'h0000), .OVERFLOW_WRAP(1'b0)
  ) dut1 (
    .clk(clk), .rst(rst), .op_i(op), .step_i(step),
    .target_i(tgt), .clear_flags_i(clr),
    .pc_o(pc1), .top_o(top1), .ras_count_o(cnt1),
    .ras_overflow_o(ov1), .ras_underflow_o(un1)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] top;
    logic [3:0]  cnt;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_pc [2];
  logic [15:0] m_st [2][8];
  int          m_n  [2];
  logic        m_ov [2];
  logic        m_un [2];

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h",
               nm, $time, act, exp);
    end
  endtask

  function automatic exp_t snap(input int k);
    exp_t e;
    e.pc  = m_pc[k];
    e.top = (m_n[k] > 0) ? m_st[k][m_n[k]-1] : 16'h0;
    e.cnt = 4'(m_n[k]);
    e.ov  = m_ov[k];
    e.un  = m_un[k];
    return e;
  endfunction

  task automatic model(input int k, input logic r,
                       input logic [2:0] o, input logic [1:0] s,
                       input logic [15:0] t, input logic c);
    logic [15:0] ra;
    logic so, su;
    so = 1'b0;
    su = 1'b0;
    if (r) begin
      m_pc[k] = 16'h0;
      m_n[k]  = 0;
      m_ov[k] = 1'b0;
      m_un[k] = 1'b0;
      return;
    end
    ra = m_pc[k] + 16'(s);
    case (o)
      3'd1: m_pc[k] = ra;
      3'd4: m_pc[k] = t;
      3'd2: begin
        if (m_n[k] < 8) begin
          m_st[k][m_n[k]] = ra;
          m_n[k]++;
        end else begin
          so = 1'b1;
          if (k == 0) begin
            for (int i = 0; i < 7; i++)
              m_st[k][i] = m_st[k][i+1];
            m_st[k][7] = ra;
          end
        end
        m_pc[k] = t;
      end
      3'd3: begin
        if (m_n[k] > 0) begin
          m_n[k]--;
          m_pc[k] = m_st[k][m_n[k]];
        end else begin
          su = 1'b1;
        end
      end
      default: ;
    endcase
    m_ov[k] = so | (m_ov[k] & ~c);
    m_un[k] = su | (m_un[k] & ~c);
  endtask

  task automatic drive(input logic r, input logic [2:0] o,
                       input logic [1:0] s, input logic [15:0] t,
                       input logic c);
    rst  = r;
    op   = o;
    step = s;
    tgt  = t;
    clr  = c;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model(k, r, o, s, t, c);
    q0.push_back(snap(0));
    q1.push_back(snap(1));
    #1;
  endtask

  // Monitor: compare every registered output once per cycle
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("pc_wrap", pc0, e.pc);
      chk("top_wrap", top0, e.top);
      chk("cnt_wrap", 16'(cnt0), 16'(e.cnt));
      chk("ovf_wrap", 16'(ov0), 16'(e.ov));
      chk("unf_wrap", 16'(un0), 16'(e.un));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("pc_drop", pc1, e.pc);
      chk("top_drop", top1, e.top);
      chk("cnt_drop", 16'(cnt1), 16'(e.cnt));
      chk("ovf_drop", 16'(ov1), 16'(e.ov));
      chk("unf_drop", 16'(un1), 16'(e.un));
    end
  end

  initial begin
    int budget;
    logic [2:0] o;
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 2, 16'h0, 0);
    drive(0, 4, 0, 16'h0010, 0);
    drive(0, 2, 1, 16'h0200, 0);
    drive(0, 3, 0, 16'h0, 0);
    drive(0, 4, 0, 16'h0000, 0);
    for (int k = 1; k <= 9; k++)
      drive(0, 2, 1, 16'(k * 16'h100), 0);
    for (int i = 0; i < 9; i++) drive(0, 3, 3, 16'hFFFF, 0);
    drive(0, 0, 0, 0, 1);
    for (int k = 1; k <= 8; k++)
      drive(0, 2, 1, 16'(k * 16'h10), 0);
    drive(0, 2, 2, 16'h0ABC, 0);
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) drive(0, 3, 0, 0, 0);
    drive(0, 3, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    drive(0, 4, 0, 16'hFFFF, 0);
    drive(0, 1, 3, 16'h0, 0);
    drive(0, 4, 0, 16'hFFFF, 0);
    drive(0, 2, 1, 16'h1234, 0);
    for (int i = 0; i < 3; i++) drive(0, 2, 1, 16'h0400, 0);
    drive(1, 3, 0, 0, 0);
    drive(0, 2, 3, 16'h0777, 0);
    drive(0, 6, 2, 16'h5555, 0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: o = 3'd2;
        3, 4, 5: o = 3'd3;
        6:       o = 3'd1;
        7:       o = 3'd4;
        8:       o = 3'd0;
        default: o = 3'($urandom_range(5, 7));
      endcase
      drive(($urandom_range(0, 99) == 0), o,
            2'($urandom_range(0, 3)),
            16'($urandom()),
            ($urandom_range(0, 7) == 0));
    end
    drive(0, 0, 0, 0, 0);
    budget = 0;
    while ((q0.size() > 0 || q1.size() > 0) && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (q0.size() > 0 || q1.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0",
               q0.size() + q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ras_unit.md
Name: fetch_ras_unit

Overview:
- Parametrised successor to the FETCH_NOP/INC_PC/RET fetch operations.
- Holds the program counter and a hardware return-address stack (RAS) of configurable depth.
- Adds CALL and JUMP operations, variable PC step, configurable overflow policy, and sticky overflow/underflow flags.
- Sits between the control unit, which issues one op per cycle, and instruction memory, which is addressed by pc_o.

Parameters:
PC_WIDTH, 16, width of PC and of every RAS entry
RAS_DEPTH, 8, number of RAS entries; must be >= 2 and a power of two
RESET_PC, 0, PC value loaded on reset
OVERFLOW_WRAP, 1, 1 = push on full stack overwrites the oldest entry; 0 = push on full stack is dropped

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  synchronous, active-high reset
op_i  input  3  operation: 0 NOP, 1 INC, 2 CALL, 3 RET, 4 JUMP; 5-7 reserved, treated as NOP
step_i  input  2  PC increment amount 0..3 for INC and CALL
target_i  input  PC_WIDTH  destination for CALL/JUMP
clear_flags_i  input  1  clears both sticky flags
pc_o  output  PC_WIDTH  current program counter (registered)
top_o  output  PC_WIDTH  top RAS entry; 0 when the stack is empty
ras_count_o  output  $clog2(RAS_DEPTH)+1  number of valid entries, 0..RAS_DEPTH
ras_overflow_o  output  1  sticky: a CALL occurred with the stack full
ras_underflow_o  output  1  sticky: a RET occurred with the stack empty

Behaviour:
- Reset (rst=1 at an edge):
  - pc_o=RESET_PC, ras_count_o=0, top_o=0, both flags 0.
  - Internal head pointer = 0.
  - RAS contents need not be cleared.
  - Reset overrides any op in the same cycle and aborts any operation mid-stream.
- All ops take effect at the next rising edge; single-cycle latency. Outputs are registered, or derived combinationally from registers only.
- Arithmetic: all PC sums are modulo 2^PC_WIDTH; wrap-around is silent.
- NOP / reserved codes: no state change.
- INC: pc <= pc + step_i. step_i=0 holds the PC.
- JUMP: pc <= target_i. RAS untouched.
- CALL:
  - Return address is ra = pc + step_i. Push ra, then pc <= target_i.
  - count < RAS_DEPTH: write ra at head, head advances (mod RAS_DEPTH), count+1.
  - count == RAS_DEPTH with OVERFLOW_WRAP=1: write ra at head, overwriting the oldest entry; head advances; count stays RAS_DEPTH; ras_overflow_o <= 1.
  - count == RAS_DEPTH with OVERFLOW_WRAP=0: no write, head and count unchanged, ras_overflow_o <= 1.
  - The PC jumps in all cases.
- RET:
  - count > 0: pc <= entry at head-1, head retreats, count-1.
  - count == 0: pc unchanged, ras_underflow_o <= 1, head and count unchanged.
  - step_i and target_i are ignored.
- top_o: entry at (head-1) mod RAS_DEPTH when count > 0, else 0.
- Sticky flags:
  - Set by the conditions above; cleared by clear_flags_i=1.
  - If a set condition and clear_flags_i coincide in the same cycle, set wins.
- Pointer arithmetic: head is $clog2(RAS_DEPTH) bits and wraps naturally. count is one bit wider so it can represent RAS_DEPTH.
- Back-to-back CALL/RET on consecutive cycles is fully supported. A RET immediately after a CALL returns the just-pushed ra.
- Storage: RAS is a register array; one write per cycle, read combinational.

Test Plan:
- Reset then INC, step_i=2, four cycles, RESET_PC=0 -> pc_o sequence 2,4,6,8; ras_count_o=0; flags 0.
- pc=0x0010, CALL step_i=1 target_i=0x0200 -> pc_o=0x0200, top_o=0x0011, count=1. Then RET -> pc_o=0x0011, count=0, top_o=0.
- Depth 8, OVERFLOW_WRAP=1: nine CALLs, each with target = 0x100*k and step_i=1, starting at pc 0 -> count=8, ras_overflow_o=1, oldest ra (0x0001) lost. Eight RETs return in LIFO order, ending at 0x0101. A ninth RET -> ras_underflow_o=1, pc unchanged.
- OVERFLOW_WRAP=0, stack full: CALL target 0x0ABC -> pc_o=0x0ABC, count stays 8, top_o unchanged, overflow=1. clear_flags_i=1 with no fault -> flags 0 next cycle. clear_flags_i plus a RET on an empty stack in the same cycle -> underflow=1.
- PC wrap: pc=0xFFFF, INC step_i=3 -> pc_o=0x0002. CALL at 0xFFFF with step_i=1 -> top_o=0x0000.
- rst asserted after three CALLs with op=RET held -> next cycle pc_o=RESET_PC, count=0, flags 0. Reserved op 6 causes no change.
